ball_speed_controller: RTL and testbench

//  Sequences the ball clock divider: drives its speed (divider compare value) and motion enable.

---
 rtl/pong_defs.sv | 37 +++
 rtl/rise_edge_detect.sv | 20 ++
 rtl/ball_speed_controller.sv | 123 ++++++++++++
 tb/tb_ball_speed_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pong_defs.sv
// Shared pong definitions: game state encodings, default speed/timing constants
// and small arithmetic helpers used by the ball speed sequencer.
package pong_defs;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SERVE  = 3'd1,
      ST_PLAY   = 3'd2,
      ST_PAUSED = 3'd3,
      ST_POINT  = 3'd4
   } game_state_t;

   localparam logic [31:0] DEF_BASE_SPEED  = 32'd1_000_000;
   localparam logic [31:0] DEF_MIN_SPEED   = 32'd250_000;
   localparam logic [31:0] DEF_SPEED_STEP  = 32'd50_000;
   localparam logic [31:0] DEF_SERVE_DELAY = 32'd25_000_000;
   localparam logic [31:0] DEF_POINT_DELAY = 32'd50_000_000;

   // The cycle that enters a timed state counts as the first delay cycle, so the
   // counter terminates at delay-2; delays below 2 still dwell one cycle.
   function automatic logic [31:0] dwell_last(input logic [31:0] delay);
      return (delay < 32'd2) ? 32'd0 : delay - 32'd2;
   endfunction

   // Checks before subtracting so a small speed value can never wrap around.
   function automatic logic [31:0] speed_after_hit(input logic [31:0] cur,
                                                   input logic [31:0] step,
                                                   input logic [31:0] min_speed);
      if (cur < step)
         return min_speed;
      else if ((cur - step) < min_speed)
         return min_speed;
      else
         return cur - step;
   endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// One-bit rising-edge detector: flags the cycle where the input goes from 0 to 1.
module rise_edge_detect (
   input  logic inClk,
   input  logic resetN,
   input  logic din,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge inClk or negedge resetN) begin
      if (!resetN)
         prev_reg <= 1'b0;
      else
         prev_reg <= din;
   end

   assign rise = din & ~prev_reg;

endmodule

// File: rtl/ball_speed_controller.sv
// Ball speed sequencer: serve delay, rally speed-up on paddle hits, pause and
// post-point freeze, driving the ball divider's compare value and enable.
module ball_speed_controller
   import pong_defs::*;
#(
   parameter logic [31:0] BASE_SPEED  = DEF_BASE_SPEED,
   parameter logic [31:0] MIN_SPEED   = DEF_MIN_SPEED,
   parameter logic [31:0] SPEED_STEP  = DEF_SPEED_STEP,
   parameter logic [31:0] SERVE_DELAY = DEF_SERVE_DELAY,
   parameter logic [31:0] POINT_DELAY = DEF_POINT_DELAY
) (
   input  logic        inClk,
   input  logic        resetN,
   input  logic        serveBtn,
   input  logic        pauseBtn,
   input  logic        paddleHit,
   input  logic        scored,
   output logic [31:0] speed,
   output logic        motion,
   output logic [7:0]  hitCount,
   output logic [2:0]  gameState
);

   localparam logic [31:0] SERVE_LAST = dwell_last(SERVE_DELAY);
   localparam logic [31:0] POINT_LAST = dwell_last(POINT_DELAY);

   game_state_t state_reg;
   logic [31:0] speed_reg;
   logic [31:0] count_reg;
   logic [7:0]  hit_reg;
   logic        motion_reg;
   logic        serve_rise;
   logic        pause_rise;

   rise_edge_detect u_serve_edge (
      .inClk  (inClk),
      .resetN (resetN),
      .din    (serveBtn),
      .rise   (serve_rise)
   );

   rise_edge_detect u_pause_edge (
      .inClk  (inClk),
      .resetN (resetN),
      .din    (pauseBtn),
      .rise   (pause_rise)
   );

   always_ff @(posedge inClk or negedge resetN) begin
      if (!resetN) begin
         state_reg  <= ST_IDLE;
         speed_reg  <= BASE_SPEED;
         count_reg  <= 32'd0;
         hit_reg    <= 8'd0;
         motion_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               motion_reg <= 1'b0;
               if (serve_rise) begin
                  state_reg <= ST_SERVE;
                  speed_reg <= BASE_SPEED;
                  hit_reg   <= 8'd0;
                  count_reg <= 32'd0;
               end
            end
            ST_SERVE: begin
               if (count_reg >= SERVE_LAST) begin
                  state_reg  <= ST_PLAY;
                  motion_reg <= 1'b1;
                  count_reg  <= 32'd0;
               end else begin
                  count_reg <= count_reg + 32'd1;
               end
            end
            ST_PLAY: begin
               if (scored) begin
                  // A hit landing in the same cycle as the score is dropped.
                  state_reg  <= ST_POINT;
                  motion_reg <= 1'b0;
                  count_reg  <= 32'd0;
               end else begin
                  if (pause_rise) begin
                     state_reg  <= ST_PAUSED;
                     motion_reg <= 1'b0;
                  end
                  if (paddleHit) begin
                     speed_reg <= speed_after_hit(speed_reg, SPEED_STEP, MIN_SPEED);
                     if (hit_reg != 8'hFF)
                        hit_reg <= hit_reg + 8'd1;
                  end
               end
            end
            ST_PAUSED: begin
               if (pause_rise) begin
                  state_reg  <= ST_PLAY;
                  motion_reg <= 1'b1;
               end
            end
            ST_POINT: begin
               if (count_reg >= POINT_LAST) begin
                  state_reg <= ST_IDLE;
                  speed_reg <= BASE_SPEED;
                  hit_reg   <= 8'd0;
                  count_reg <= 32'd0;
               end else begin
                  count_reg <= count_reg + 32'd1;
               end
            end
            default: begin
               state_reg  <= ST_IDLE;
               motion_reg <= 1'b0;
            end
         endcase
      end
   end

   assign speed     = speed_reg;
   assign motion    = motion_reg;
   assign hitCount  = hit_reg;
   assign gameState = state_reg;

endmodule

// File: tb/tb_ball_speed_controller.sv
// Directed bench for ball_speed_controller with small speed/delay parameters.
module tb_ball_speed_controller;

   logic        inClk = 1'b0;
   logic        resetN;
   logic        serveBtn;
   logic        pauseBtn;
   logic        paddleHit;
   logic        scored;
   logic [31:0] speed;
   logic        motion;
   logic [7:0]  hitCount;
   logic [2:0]  gameState;

   int vectors = 0;
   int miscompares = 0;

   always #5 inClk = ~inClk;

   ball_speed_controller #(
      .BASE_SPEED  (32'd100),
      .MIN_SPEED   (32'd60),
      .SPEED_STEP  (32'd15),
      .SERVE_DELAY (32'd4),
      .POINT_DELAY (32'd6)
   ) dut (
      .inClk     (inClk),
      .resetN    (resetN),
      .serveBtn  (serveBtn),
      .pauseBtn  (pauseBtn),
      .paddleHit (paddleHit),
      .scored    (scored),
      .speed     (speed),
      .motion    (motion),
      .hitCount  (hitCount),
      .gameState (gameState)
   );

   task automatic step();
      @(posedge inClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] st, input logic [31:0] spd,
                          input logic [31:0] mot, input logic [31:0] hits);
      chk({tag, ".state"},  32'(gameState), st);
      chk({tag, ".speed"},  speed,          spd);
      chk({tag, ".motion"}, 32'(motion),    mot);
      chk({tag, ".hits"},   32'(hitCount),  hits);
   endtask

   initial begin
      resetN = 1'b0; serveBtn = 1'b0; pauseBtn = 1'b0; paddleHit = 1'b0; scored = 1'b0;
      step(); step();
      chk_all("reset", 0, 100, 0, 0);
      resetN = 1'b1;
      step();
      chk_all("idle", 0, 100, 0, 0);

      // Serve edge in cycle 0; serveBtn then stays held through the rally.
      serveBtn = 1'b1;
      chk("serve.c0.motion", 32'(motion), 0);
      step();
      chk("serve.c1.state", 32'(gameState), 1);
      chk("serve.c1.motion", 32'(motion), 0);
      step();
      chk("serve.c2.motion", 32'(motion), 0);
      step();
      chk("serve.c3.motion", 32'(motion), 0);
      chk("serve.c3.state", 32'(gameState), 1);
      step();
      chk_all("play.start", 2, 100, 1, 0);

      // Rally speed-up with clamp at MIN.
      paddleHit = 1'b1; step(); paddleHit = 1'b0;
      chk_all("hit1", 2, 85, 1, 1);
      paddleHit = 1'b1; step(); paddleHit = 1'b0;
      chk_all("hit2", 2, 70, 1, 2);
      paddleHit = 1'b1; step(); paddleHit = 1'b0;
      chk_all("hit3.clamp", 2, 60, 1, 3);
      paddleHit = 1'b1; step(); paddleHit = 1'b0;
      chk_all("hit4.clamp", 2, 60, 1, 4);

      // Pause; hits and scores ignored while paused.
      pauseBtn = 1'b1; step();
      chk_all("pause", 3, 60, 0, 4);
      paddleHit = 1'b1; step(); paddleHit = 1'b0;
      chk_all("pause.hit", 3, 60, 0, 4);
      scored = 1'b1; step(); scored = 1'b0;
      chk_all("pause.score", 3, 60, 0, 4);
      step();
      chk("pause.held", 32'(gameState), 3);
      pauseBtn = 1'b0; step();
      pauseBtn = 1'b1; step();
      chk_all("resume", 2, 60, 1, 4);
      pauseBtn = 1'b0;

      // Score and hit together: score wins, hit dropped; 6-cycle freeze.
      paddleHit = 1'b1; scored = 1'b1; step(); paddleHit = 1'b0; scored = 1'b0;
      chk_all("point", 4, 60, 0, 4);
      step(); step(); step(); step();
      chk_all("point.c5", 4, 60, 0, 4);
      step();
      chk_all("point.idle", 0, 100, 0, 0);

      // serveBtn held since the first serve: no retrigger in IDLE.
      repeat (6) step();
      chk("held.serve.state", 32'(gameState), 0);
      serveBtn = 1'b0;
      pauseBtn = 1'b1; step(); pauseBtn = 1'b0;
      chk("idle.pause.state", 32'(gameState), 0);

      // Async reset mid-SERVE.
      serveBtn = 1'b1; step(); step();
      chk("serve2.state", 32'(gameState), 1);
      serveBtn = 1'b0;
      #2 resetN = 1'b0;
      #1;
      chk_all("async.rst.serve", 0, 100, 0, 0);
      step();
      resetN = 1'b1;
      step(); step();
      chk_all("post.rst.idle", 0, 100, 0, 0);

      // New rally: saturate hitCount, then async reset mid-PLAY.
      serveBtn = 1'b1; step(); serveBtn = 1'b0;
      step(); step(); step();
      chk_all("serve3.play", 2, 100, 1, 0);
      paddleHit = 1'b1;
      repeat (260) step();
      paddleHit = 1'b0;
      chk_all("hits.saturate", 2, 60, 1, 255);
      #2 resetN = 1'b0;
      #1;
      chk_all("async.rst.play", 0, 100, 0, 0);
      step();
      resetN = 1'b1;
      step();
      chk_all("final.idle", 0, 100, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
